// File: rtl/bram2_be.sv
`default_nettype none
// ============================================================================
// bram2_be : true dual-port RAM with byte-lane write enables, per-port write
//            mode, optional output register, read-valid and collision flags
// Revision : 1.0
// ============================================================================
module bram2_be #(
  parameter int PIPELINED    = 0,
  parameter int ADDR_WIDTH   = 1,
  parameter int DATA_WIDTH   = 8,
  parameter int CHUNKSIZE    = 8,
  parameter int WE_WIDTH     = DATA_WIDTH / CHUNKSIZE,
  parameter int MEMSIZE      = 1,
  parameter int WRITE_MODE_A = 0,
  parameter int WRITE_MODE_B = 0
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  ENA,
  input  logic [WE_WIDTH-1:0]   WEA,
  input  logic [ADDR_WIDTH-1:0] ADDRA,
  input  logic [DATA_WIDTH-1:0] DIA,
  output logic [DATA_WIDTH-1:0] DOA,
  output logic                  VALIDA,
  input  logic                  ENB,
  input  logic [WE_WIDTH-1:0]   WEB,
  input  logic [ADDR_WIDTH-1:0] ADDRB,
  input  logic [DATA_WIDTH-1:0] DIB,
  output logic [DATA_WIDTH-1:0] DOB,
  output logic                  VALIDB,
  output logic                  COLLISION
);
  localparam int          IDX_W     = (MEMSIZE > 1) ? $clog2(MEMSIZE) : 1;
  localparam logic [32:0] MEMSIZE_W = 33'(MEMSIZE);

  logic [DATA_WIDTH-1:0] mem_q [MEMSIZE];

  logic                  a_act, b_act, a_wr, b_wr, a_in, b_in, same;
  logic [DATA_WIDTH-1:0] a_old, b_old, a_new, b_new;
  logic [DATA_WIDTH-1:0] doa1_d, dob1_d, doa1_q, dob1_q;
  logic                  va1_d, vb1_d, va1_q, vb1_q;
  logic                  collision_d, collision_q;

  always_comb begin
    a_act = ENA & ~RST;
    b_act = ENB & ~RST;
    a_wr  = a_act & (|WEA);
    b_wr  = b_act & (|WEB);
    a_in  = 33'(ADDRA) < MEMSIZE_W;
    b_in  = 33'(ADDRB) < MEMSIZE_W;
    same  = (ADDRA == ADDRB);
    a_old = a_in ? mem_q[ADDRA[IDX_W-1:0]] : '0;
    b_old = b_in ? mem_q[ADDRB[IDX_W-1:0]] : '0;
    // Resolved post-write word at each address; A's lanes are applied last so it wins
    a_new = a_old;
    b_new = b_old;
    for (int i = 0; i < WE_WIDTH; i++) begin
      if (b_wr && same && WEB[i]) a_new[i*CHUNKSIZE +: CHUNKSIZE] = DIB[i*CHUNKSIZE +: CHUNKSIZE];
      if (a_wr && WEA[i])         a_new[i*CHUNKSIZE +: CHUNKSIZE] = DIA[i*CHUNKSIZE +: CHUNKSIZE];
      if (b_wr && WEB[i])         b_new[i*CHUNKSIZE +: CHUNKSIZE] = DIB[i*CHUNKSIZE +: CHUNKSIZE];
      if (a_wr && same && WEA[i]) b_new[i*CHUNKSIZE +: CHUNKSIZE] = DIA[i*CHUNKSIZE +: CHUNKSIZE];
    end
  end

  always_comb begin
    doa1_d = doa1_q;
    va1_d  = 1'b0;
    if (a_act) begin
      if (!a_wr || WRITE_MODE_A == 1) begin
        doa1_d = a_old;
        va1_d  = 1'b1;
      end else if (WRITE_MODE_A == 0) begin
        doa1_d = a_in ? a_new : '0;
        va1_d  = 1'b1;
      end
    end
    dob1_d = dob1_q;
    vb1_d  = 1'b0;
    if (b_act) begin
      if (!b_wr || WRITE_MODE_B == 1) begin
        dob1_d = b_old;
        vb1_d  = 1'b1;
      end else if (WRITE_MODE_B == 0) begin
        dob1_d = b_in ? b_new : '0;
        vb1_d  = 1'b1;
      end
    end
    collision_d = a_act & b_act & same & ((|WEA) | (|WEB));
  end

  // Both ports may target the same word; they then carry identical resolved data
  always_ff @(posedge CLK) begin
    if (b_wr && b_in) mem_q[ADDRB[IDX_W-1:0]] <= b_new;
    if (a_wr && a_in) mem_q[ADDRA[IDX_W-1:0]] <= a_new;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      doa1_q      <= '0;
      dob1_q      <= '0;
      va1_q       <= 1'b0;
      vb1_q       <= 1'b0;
      collision_q <= 1'b0;
    end else begin
      doa1_q      <= doa1_d;
      dob1_q      <= dob1_d;
      va1_q       <= va1_d;
      vb1_q       <= vb1_d;
      collision_q <= collision_d;
    end
  end

  assign COLLISION = collision_q;

  generate
    if (PIPELINED != 0) begin : g_pipe
      logic [DATA_WIDTH-1:0] doa2_q, dob2_q;
      logic                  va2_q, vb2_q;
      always_ff @(posedge CLK) begin
        if (RST) begin
          doa2_q <= '0;
          dob2_q <= '0;
          va2_q  <= 1'b0;
          vb2_q  <= 1'b0;
        end else begin
          doa2_q <= doa1_q;
          dob2_q <= dob1_q;
          va2_q  <= va1_q;
          vb2_q  <= vb1_q;
        end
      end
      assign DOA    = doa2_q;
      assign DOB    = dob2_q;
      assign VALIDA = va2_q;
      assign VALIDB = vb2_q;
    end else begin : g_nopipe
      assign DOA    = doa1_q;
      assign DOB    = dob1_q;
      assign VALIDA = va1_q;
      assign VALIDB = vb1_q;
    end
  endgenerate
endmodule
`default_nettype wire

// File: tb/tb_bram2_be.sv
`default_nettype none
// tb_bram2_be: two bram2_be configurations share one stimulus stream; a reference
// model fills a per-port scoreboard that is drained on every clock.
module tb_bram2_be;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, ena, enb;
  logic [3:0]  wea, web, addra, addrb;
  logic [31:0] dia, dib;
  logic [31:0] doa0, dob0, doa1, dob1;
  logic        va0, vb0, va1, vb1, coll0, coll1;

  bram2_be #(.PIPELINED(0), .ADDR_WIDTH(4), .DATA_WIDTH(32), .CHUNKSIZE(8), .WE_WIDTH(4),
             .MEMSIZE(16), .WRITE_MODE_A(0), .WRITE_MODE_B(1)) u0 (
    .CLK(clk), .RST(rst),
    .ENA(ena), .WEA(wea), .ADDRA(addra), .DIA(dia), .DOA(doa0), .VALIDA(va0),
    .ENB(enb), .WEB(web), .ADDRB(addrb), .DIB(dib), .DOB(dob0), .VALIDB(vb0),
    .COLLISION(coll0));

  bram2_be #(.PIPELINED(1), .ADDR_WIDTH(4), .DATA_WIDTH(32), .CHUNKSIZE(8), .WE_WIDTH(4),
             .MEMSIZE(5), .WRITE_MODE_A(2), .WRITE_MODE_B(0)) u1 (
    .CLK(clk), .RST(rst),
    .ENA(ena), .WEA(wea), .ADDRA(addra), .DIA(dia), .DOA(doa1), .VALIDA(va1),
    .ENB(enb), .WEB(web), .ADDRB(addrb), .DIB(dib), .DOB(dob1), .VALIDB(vb1),
    .COLLISION(coll1));

  localparam int MS[2]     = '{16, 5};
  localparam int LAT[2]    = '{0, 1};
  localparam int MODE_A[2] = '{0, 2};
  localparam int MODE_B[2] = '{1, 0};

  typedef struct { int due; logic [31:0] data; } exp_t;
  exp_t        sbq[4][$];
  logic [31:0] mdl[2][16];
  string       nm[4] = '{"u0.A", "u0.B", "u1.A", "u1.B"};
  int          cyc = 0;
  int          n_tests = 0;
  int          n_fail = 0;

  task automatic idle();
    ena = 0; enb = 0; wea = 0; web = 0; addra = 0; addrb = 0; dia = 0; dib = 0;
  endtask

  // Model the access about to be clocked, advance one edge, then drain the scoreboard
  task automatic cycle();
    logic [31:0] oa, ob, na, nb;
    logic        ia, ib;
    logic        vv[4];
    logic [31:0] vd[4];
    exp_t        e;
    if (rst) begin
      for (int k = 0; k < 4; k++) sbq[k].delete();
    end else begin
      for (int d = 0; d < 2; d++) begin
        ia = int'(addra) < MS[d];
        ib = int'(addrb) < MS[d];
        oa = ia ? mdl[d][addra] : 32'd0;
        ob = ib ? mdl[d][addrb] : 32'd0;
        if (enb && web != 0 && ib)
          for (int i = 0; i < 4; i++) if (web[i]) mdl[d][addrb][i*8 +: 8] = dib[i*8 +: 8];
        if (ena && wea != 0 && ia)
          for (int i = 0; i < 4; i++) if (wea[i]) mdl[d][addra][i*8 +: 8] = dia[i*8 +: 8];
        na = ia ? mdl[d][addra] : 32'd0;
        nb = ib ? mdl[d][addrb] : 32'd0;
        if (ena && !(wea != 0 && MODE_A[d] == 2)) begin
          e.due  = cyc + 1 + LAT[d];
          e.data = (wea != 0 && MODE_A[d] == 0) ? na : oa;
          sbq[2*d].push_back(e);
        end
        if (enb && !(web != 0 && MODE_B[d] == 2)) begin
          e.due  = cyc + 1 + LAT[d];
          e.data = (web != 0 && MODE_B[d] == 0) ? nb : ob;
          sbq[2*d+1].push_back(e);
        end
      end
    end
    @(posedge clk);
    #1;
    cyc++;
    vv = '{va0, vb0, va1, vb1};
    vd = '{doa0, dob0, doa1, dob1};
    for (int k = 0; k < 4; k++) begin
      if (vv[k] === 1'b1) begin
        n_tests++;
        if (sbq[k].size() == 0 || sbq[k][0].due != cyc) begin
          n_fail++;
          $display("FAIL sb %s unexpected valid at cyc %0d data=%h", nm[k], cyc, vd[k]);
        end else begin
          e = sbq[k].pop_front();
          if (vd[k] !== e.data) begin
            n_fail++;
            $display("FAIL sb %s data at cyc %0d got=%h exp=%h", nm[k], cyc, vd[k], e.data);
          end
        end
      end else if (sbq[k].size() != 0 && sbq[k][0].due <= cyc) begin
        n_tests++;
        n_fail++;
        e = sbq[k].pop_front();
        $display("FAIL sb %s missing valid at cyc %0d valid=%b exp_data=%h", nm[k], cyc, vv[k], e.data);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1; idle();
    cycle(); cycle();
    n_tests++;
    if ({doa0, dob0, doa1, dob1} !== 128'd0) begin
      n_fail++; $display("FAIL reset_data got=%h exp=0", {doa0, dob0, doa1, dob1});
    end
    n_tests++;
    if ({va0, vb0, va1, vb1, coll0, coll1} !== 6'b0) begin
      n_fail++; $display("FAIL reset_flags got=%b exp=000000", {va0, vb0, va1, vb1, coll0, coll1});
    end
    rst = 0;
  endtask

  task automatic test_init();
    for (int a = 0; a < 16; a++) begin
      idle(); ena = 1; wea = 4'hF; addra = 4'(a); dia = 32'h1000 + 32'(a);
      cycle();
    end
    idle(); cycle();
  endtask

  task automatic test_byte_enable();
    idle();
    ena = 1; wea = 4'hF; addra = 3; dia = 32'h11223344;
    enb = 1; web = 4'hF; addrb = 4; dib = 32'h11223344;
    cycle();
    wea = 4'b0101; dia = 32'hAABBCCDD;
    web = 4'b0101; dib = 32'hAABBCCDD;
    cycle();
    n_tests++;
    if (doa0 !== 32'h11BB33DD) begin n_fail++; $display("FAIL be_write_first got=%h exp=11bb33dd", doa0); end
    n_tests++;
    if (dob0 !== 32'h11223344) begin n_fail++; $display("FAIL be_read_first got=%h exp=11223344", dob0); end
    wea = 0; web = 0;
    cycle();
    n_tests++;
    if ({doa0, dob0} !== {32'h11BB33DD, 32'h11BB33DD}) begin
      n_fail++; $display("FAIL be_readback got=%h exp=11bb33dd11bb33dd", {doa0, dob0});
    end
    idle(); cycle();
  endtask

  task automatic test_collision_ww();
    idle();
    ena = 1; wea = 4'hF;    addra = 1; dia = 32'hAAAAAAAA;
    enb = 1; web = 4'b1100; addrb = 1; dib = 32'hBBBBBBBB;
    cycle();
    n_tests++;
    if ({coll0, coll1} !== 2'b11) begin n_fail++; $display("FAIL ww_collision got=%b exp=11", {coll0, coll1}); end
    idle(); cycle();
    n_tests++;
    if ({coll0, coll1} !== 2'b00) begin n_fail++; $display("FAIL ww_collision_pulse got=%b exp=00", {coll0, coll1}); end
    ena = 1; addra = 1;
    cycle();
    n_tests++;
    if (doa0 !== 32'hAAAAAAAA) begin n_fail++; $display("FAIL ww_readback got=%h exp=aaaaaaaa", doa0); end
    idle(); cycle();
  endtask

  task automatic test_collision_rw();
    idle();
    ena = 1; wea = 4'hF; addra = 7; dia = 32'h9;
    cycle();
    dia = 32'h5;
    enb = 1; addrb = 7;
    cycle();
    n_tests++;
    if (dob0 !== 32'h9) begin n_fail++; $display("FAIL rw_pre_write got=%h exp=9", dob0); end
    n_tests++;
    if ({coll0, coll1} !== 2'b11) begin n_fail++; $display("FAIL rw_collision got=%b exp=11", {coll0, coll1}); end
    ena = 0; wea = 0;
    cycle();
    n_tests++;
    if (dob0 !== 32'h5) begin n_fail++; $display("FAIL rw_next_read got=%h exp=5", dob0); end
    n_tests++;
    if ({coll0, coll1} !== 2'b00) begin n_fail++; $display("FAIL rw_collision_pulse got=%b exp=00", {coll0, coll1}); end
    idle(); cycle();
  endtask

  task automatic test_latency();
    logic [5:0] pat;
    logic       nc_seen;
    for (int k = 0; k < 6; k++) begin
      idle();
      if (k < 4) begin ena = 1; addra = 4'(k); end
      cycle();
      pat[k] = va1;
    end
    n_tests++;
    if (pat !== 6'b011110) begin n_fail++; $display("FAIL pipe_valid_pattern got=%b exp=011110", pat); end
    idle(); ena = 1; wea = 4'hF; addra = 2; dia = 32'h77;
    cycle();
    nc_seen = va1;
    idle();
    cycle(); nc_seen = nc_seen | va1;
    cycle(); nc_seen = nc_seen | va1;
    n_tests++;
    if (nc_seen !== 1'b0) begin n_fail++; $display("FAIL no_change_valid got=%b exp=0", nc_seen); end
  endtask

  task automatic test_reset_midop();
    idle(); ena = 1; wea = 4'hF; addra = 2; dia = 32'hDEAD;
    cycle();
    wea = 0;
    cycle();
    rst = 1; wea = 4'hF; dia = 32'hBEEF;
    cycle();
    n_tests++;
    if ({va1, doa1, coll1, doa0} !== {1'b0, 32'd0, 1'b0, 32'd0}) begin
      n_fail++; $display("FAIL reset_kill got va1=%b doa1=%h coll1=%b doa0=%h exp=0", va1, doa1, coll1, doa0);
    end
    rst = 0; idle();
    cycle();
    n_tests++;
    if (va1 !== 1'b0) begin n_fail++; $display("FAIL reset_late_valid got=%b exp=0", va1); end
    ena = 1; addra = 2;
    cycle();
    idle();
    cycle();
    n_tests++;
    if ({doa0, doa1} !== {32'hDEAD, 32'hDEAD}) begin
      n_fail++; $display("FAIL reset_readback got=%h exp=0000dead0000dead", {doa0, doa1});
    end
  endtask

  task automatic test_out_of_range();
    idle(); ena = 1; addra = 6;
    cycle();
    idle();
    cycle();
    n_tests++;
    if ({va1, doa1} !== {1'b1, 32'd0}) begin
      n_fail++; $display("FAIL oor_read got va1=%b doa1=%h exp valid=1 data=0", va1, doa1);
    end
    enb = 1; web = 4'hF; addrb = 6; dib = 32'hCAFEF00D;
    cycle();
    for (int a = 0; a < 5; a++) begin
      idle(); ena = 1; addra = 4'(a);
      cycle();
    end
    idle(); cycle(); cycle();
  endtask

  task automatic test_drain();
    idle(); cycle(); cycle(); cycle();
    for (int k = 0; k < 4; k++) begin
      n_tests++;
      if (sbq[k].size() != 0) begin
        n_fail++; $display("FAIL drain %s pending=%0d exp=0", nm[k], sbq[k].size());
      end
    end
  endtask

  initial begin
    rst = 1;
    idle();
    test_reset();
    test_init();
    test_byte_enable();
    test_collision_ww();
    test_collision_rw();
    test_latency();
    test_reset_midop();
    test_out_of_range();
    test_drain();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/bram2_be.md
# bram2_be

True dual-port block RAM with per-byte write enables, a per-port write mode, optional output pipelining, read-valid strobes and cross-port collision reporting. It is the next generation of the dual-port BRAM primitive. Both ports share one clock. It serves wide-datapath memories (caches, tag/data arrays, scratchpads) that need partial writes and deterministic collision behaviour.

## Interface
Parameters:
- PIPELINED, 0: 0 gives 1-cycle read latency; 1 adds an output register for 2-cycle latency.
- ADDR_WIDTH, 1: address width.
- DATA_WIDTH, 8: word width. Must be a multiple of CHUNKSIZE.
- CHUNKSIZE, 8: bits per write-enable lane.
- WE_WIDTH, DATA_WIDTH/CHUNKSIZE: number of write-enable lanes.
- MEMSIZE, 1: number of words. Must be ≤ 2^ADDR_WIDTH.
- WRITE_MODE_A, 0: port A mode. 0 = write-first, 1 = read-first, 2 = no-change.
- WRITE_MODE_B, 0: port B mode, same encoding.

Ports:
- CLK  in  1  Single clock for both ports.
- RST  in  1  Synchronous, active-high reset.
- ENA  in  1  Port A access enable.
- WEA  in  WE_WIDTH  Port A lane write enables.
- ADDRA  in  ADDR_WIDTH  Port A address.
- DIA  in  DATA_WIDTH  Port A write data.
- DOA  out  DATA_WIDTH  Port A read data.
- VALIDA  out  1  Pulse marking new data on DOA.
- ENB, WEB, ADDRB, DIB, DOB, VALIDB: identical set for port B.
- COLLISION  out  1  Registered pulse when both ports hit the same address and at least one of them writes.

## Operation
- Access type (per port, per cycle, EN=1):
  - WE == 0 is a read.
  - Any WE bit set is a write. Lane i (bits i*CHUNKSIZE +: CHUNKSIZE) is written only when WE[i]=1.
- Write-port output register, by mode:
  - Write-first: loads the merged word (new lanes where WE set, old lanes otherwise).
  - Read-first: loads the pre-write word.
  - No-change: holds its value.
- Read: the output register loads RAM[ADDR].
- EN=0: output register holds.
- Cross-port collision (ENA & ENB & ADDRA==ADDRB & (|WEA | |WEB)):
  - Write/write: port A wins on lanes both ports enable. B's lanes that A does not enable are still written.
  - Read/write: the reading port returns the pre-write word.
  - COLLISION pulses one cycle after the collision.
- Address ≥ MEMSIZE:
  - Writes are dropped.
  - Reads return 0.
  - Still counts as an access for VALID.
  - Still participates in collision detection.
- VALIDx pulses once per access that loads the port's output register. A no-change write does not produce a pulse.
- Reset:
  - While RST=1, ENA and ENB are ignored: no RAM write, no read.
  - DOA, DOB, the internal stage-1/stage-2 registers, VALIDA, VALIDB and COLLISION clear to 0 on the next edge.
  - RAM contents are not affected by reset.

## Timing
- PIPELINED=0: access at edge n. DO and VALID are updated at edge n, visible in cycle n+1. VALID is high for that one cycle only.
- PIPELINED=1: stage 2 copies stage 1 every cycle, so DO and VALID appear one cycle later (edge n+1). Back-to-back accesses give back-to-back VALID pulses.
- Full throughput: one access per port per cycle, no stalls.
- Write visibility: a write at edge n is visible to a read on either port at edge n+1.
- COLLISION is registered: the collision cycle sampled at edge n gives COLLISION high in cycle n+1. It obeys PIPELINED=0 timing regardless of the PIPELINED setting.
- Reset mid-operation: with PIPELINED=1, asserting RST at edge n kills any in-flight stage-2 VALID, so no pulse appears after edge n.
- Reset release: the first access after RST deasserts behaves normally.

## Test plan
- Byte-enable write. Setup: DATA_WIDTH=32, RAM[3]=0x11223344. A writes WEA=4'b0101, DIA=0xAABBCCDD. Required: A reads back 0x11BB33DD. With write-first, DOA shows 0x11BB33DD on the write itself. With read-first, DOA shows 0x11223344.
- Write/write collision. A: WEA=4'hF, DIA=0xAAAAAAAA. B: WEB=4'b1100, DIB=0xBBBBBBBB, same address. Required: word reads 0xAAAAAAAA, and COLLISION=1 for exactly one cycle.
- Read/write collision. A writes 0x5 to addr 7 (old value 0x9) while B reads addr 7. Required: DOB=0x9, next-cycle read returns 0x5, COLLISION pulses.
- Latency. PIPELINED=1, four back-to-back reads on port A. Required: VALIDA high for four consecutive cycles starting 2 cycles after the first access, with data in order. With no-change mode, a write yields no VALIDA pulse.
- Reset. Write 0xDEAD to addr 2, then issue a read with PIPELINED=1. Assert RST the following cycle. Required: no VALIDA, DOA=0, COLLISION=0. A post-reset read of addr 2 returns 0xDEAD. A write issued during RST is not stored.
- Out of range. MEMSIZE=5, read addr 6. Required: DOA=0 with VALIDA pulse. A write to addr 6 leaves addrs 0–4 unchanged.
